// File: rtl/rst_seq_pkg.sv
`timescale 1ns/1ps
// Shared types and default constants for the staged reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_STAGES      = 3;
  localparam int unsigned DEF_SYNC_DEPTH  = 2;
  localparam int unsigned DEF_HOLD_CYCLES = 16;

endpackage

// File: rtl/rst_sync_n.sv
`timescale 1ns/1ps
// Reset synchronizer: asserts asynchronously, deasserts after DEPTH clk edges.
// Ports:
//   clk        - clock
//   rst_n      - raw reset, asynchronous, active-low
//   sync_rst_n - synchronized reset, active-low
module rst_sync_n #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_rst_n
);

  logic [DEPTH-1:0] chain;

  // Shift a constant one through the chain; any rst_n low clears it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[DEPTH-2:0], 1'b1};
    end
  end

  assign sync_rst_n = chain[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
`timescale 1ns/1ps
// Staged reset sequencer: releases STAGES resets in order, HOLD_CYCLES apart,
// after a synchronized board reset; sw_req in DONE restarts the sequence.
// Ports:
//   clk         - clock
//   rst         - board reset, asynchronous, active-low
//   sw_req      - single-cycle soft re-sequence request (honoured only in DONE)
//   stage_rst_n - per-stage reset, active-low, bit 0 released first
//   stage_rst   - per-stage reset, active-high (complement of stage_rst_n)
//   done        - all stages released
//   busy        - sequence in progress (complement of done)
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned STAGES      = DEF_STAGES,
  parameter int unsigned SYNC_DEPTH  = DEF_SYNC_DEPTH,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_req,
  output logic [STAGES-1:0] stage_rst_n,
  output logic [STAGES-1:0] stage_rst,
  output logic              done,
  output logic              busy
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned IW = (STAGES > 1) ? $clog2(STAGES) : 1;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [STAGES-1:0] stage_rst_n_d;
  logic              done_d;
  logic              tick;
  logic              sync_rst_n;

  rst_sync_n #(
    .DEPTH(SYNC_DEPTH)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst),
    .sync_rst_n(sync_rst_n)
  );

  // State, counters and every reset output come straight from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_SYNC;
      cnt_q       <= '0;
      idx_q       <= '0;
      stage_rst_n <= '0;
      stage_rst   <= '1;
      done        <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stage_rst_n <= stage_rst_n_d;
      stage_rst   <= ~stage_rst_n_d;
      done        <= done_d;
      busy        <= ~done_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    stage_rst_n_d = stage_rst_n;
    done_d        = done;
    tick          = 1'b0;

    case (state_q)
      // The edge that first sees the synchronizer high is already the
      // first hold cycle, so stage 0 lands at SYNC_DEPTH + HOLD_CYCLES.
      ST_SYNC: begin
        if (sync_rst_n) begin
          state_d = ST_HOLD;
          tick    = 1'b1;
        end
      end
      ST_HOLD: begin
        tick = 1'b1;
      end
      ST_DONE: begin
        if (sw_req) begin
          state_d       = ST_HOLD;
          stage_rst_n_d = '0;
          done_d        = 1'b0;
          cnt_d         = '0;
          idx_d         = '0;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase

    // One hold cycle elapsed: either release the current stage or keep counting.
    if (tick) begin
      if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
        stage_rst_n_d = stage_rst_n | (STAGES'(1) << idx_q);
        cnt_d         = '0;
        if (idx_q == IW'(STAGES - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

endmodule
